// File: rtl/mig_pkg.sv
// ============================================================================
// Module      : mig_pkg
// Description : Shared types and helpers for the MIG truth-table engine:
//               operand/node config structs, FSM state encoding and the
//               operand-select width function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mig_pkg;

    // Widest operand select the decoder supports (covers up to 255 sources).
    localparam int SEL_W_MAX  = 8;

    // Select code that always reads as logic 0.
    localparam int SEL_CONST0 = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE_ST = 2'd2
    } state_e;

    // One majority-node operand: optional complement plus source select.
    typedef struct packed {
        logic                 inv;
        logic [SEL_W_MAX-1:0] sel;
    } operand_t;

    // Full node configuration: operand 0 sits in the LSBs.
    typedef struct packed {
        operand_t [2:0] op;
    } node_cfg_t;

    // Bits needed to address constant 0, every input and every node.
    function automatic int sel_width(input int num_inputs, input int num_nodes);
        return $clog2(1 + num_inputs + num_nodes);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mig_eval.sv
// ============================================================================
// Module      : mig_eval
// Description : Purely combinational evaluation of a configured majority-
//               inverter graph for one minterm. Nodes are evaluated in index
//               order; references to the same or a later node read as 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mig_eval import mig_pkg::*; #(
    parameter int NUM_INPUTS = 7,
    parameter int NUM_NODES  = 8,
    parameter int SEL_W      = sel_width(NUM_INPUTS, NUM_NODES),
    localparam int OP_W      = SEL_W + 1,
    localparam int CFG_W     = 3 * OP_W
) (
    input  logic [NUM_NODES*CFG_W-1:0] node_cfg,
    input  logic [OP_W-1:0]            out_cfg,
    input  logic [NUM_INPUTS-1:0]      x,
    output logic                       f
);

    logic [NUM_NODES-1:0] nodes;
    logic                 op_a;
    logic                 op_b;
    logic                 op_c;

    // Decode one raw {inv, sel} operand; only nodes below 'limit' are visible.
    function automatic logic operand_val(input logic [OP_W-1:0]      raw,
                                         input logic [NUM_NODES-1:0] nv,
                                         input int                   limit);
        operand_t op;
        int       s;
        logic     v;
        op                  = '0;
        op.inv              = raw[SEL_W];
        op.sel[SEL_W-1:0]   = raw[SEL_W-1:0];
        s                   = int'(op.sel);
        v                   = 1'b0;
        if (s != SEL_CONST0) begin
            for (int b = 0; b < NUM_INPUTS; b++) begin
                if (s == b + 1) v = x[b];
            end
            for (int j = 0; j < NUM_NODES; j++) begin
                if (j < limit && s == NUM_INPUTS + 1 + j) v = nv[j];
            end
        end
        return v ^ op.inv;
    endfunction

    // Ripple through the nodes in index order, then pick the output operand.
    always_comb begin
        nodes = '0;
        op_a  = 1'b0;
        op_b  = 1'b0;
        op_c  = 1'b0;
        for (int i = 0; i < NUM_NODES; i++) begin
            op_a     = operand_val(node_cfg[i*CFG_W          +: OP_W], nodes, i);
            op_b     = operand_val(node_cfg[i*CFG_W + OP_W   +: OP_W], nodes, i);
            op_c     = operand_val(node_cfg[i*CFG_W + 2*OP_W +: OP_W], nodes, i);
            nodes[i] = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
        end
        f = operand_val(out_cfg, nodes, NUM_NODES);
    end

endmodule

`default_nettype wire

// File: rtl/mig_tt_engine.sv
// ============================================================================
// Module      : mig_tt_engine
// Description : Programmable MIG evaluator. Enumerates every minterm, packs
//               the function values into TT_WORD-bit words and streams them
//               over a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mig_tt_engine import mig_pkg::*; #(
    parameter int NUM_INPUTS = 7,
    parameter int NUM_NODES  = 8,
    parameter int TT_WORD    = 32,
    parameter int SEL_W      = sel_width(NUM_INPUTS, NUM_NODES),
    localparam int NODE_W    = $clog2(NUM_NODES + 1),
    localparam int OP_W      = SEL_W + 1,
    localparam int CFG_W     = 3 * OP_W,
    localparam int LOG_TW    = $clog2(TT_WORD),
    localparam int M_W       = NUM_INPUTS + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [NODE_W-1:0]  cfg_node,
    input  logic [CFG_W-1:0]   cfg_data,
    input  logic               start,
    output logic               busy,
    output logic [TT_WORD-1:0] tt_data,
    output logic               tt_valid,
    input  logic               tt_ready,
    output logic               done
);

    state_e                   state;
    state_e                   state_nx;
    logic [NUM_NODES*CFG_W-1:0] node_cfg;
    logic [OP_W-1:0]          out_cfg;
    logic [M_W-1:0]           m;
    logic [TT_WORD-2:0]       pack;
    logic [TT_WORD-1:0]       word_cat;
    logic [LOG_TW-1:0]        bit_idx;
    logic                     last_bit;
    logic                     advance;
    logic                     load;
    logic                     final_hs;
    logic                     cfg_open;
    logic                     f;

    mig_eval #(
        .NUM_INPUTS (NUM_INPUTS),
        .NUM_NODES  (NUM_NODES),
        .SEL_W      (SEL_W)
    ) u_eval (
        .node_cfg (node_cfg),
        .out_cfg  (out_cfg),
        .x        (m[NUM_INPUTS-1:0]),
        .f        (f)
    );

    // A word is finished when the low counter bits are all ones; the final
    // bit may only be taken if the output register is empty or draining now.
    assign bit_idx  = m[LOG_TW-1:0];
    assign last_bit = &bit_idx;
    assign advance  = (state == RUN) && !m[NUM_INPUTS] &&
                      (!last_bit || !tt_valid || tt_ready);
    assign load     = advance && last_bit;
    assign final_hs = (state == RUN) && m[NUM_INPUTS] && tt_valid && tt_ready;
    assign word_cat = {f, pack};

    // Config is writable only while not busy, and not in the start cycle.
    assign cfg_open = cfg_we && (state != RUN) && !((state == IDLE) && start);

    // Config register file: nodes 0..NUM_NODES-1 plus the output select.
    always_ff @(posedge clk) begin
        if (rst) begin
            node_cfg <= '0;
            out_cfg  <= '0;
        end else if (cfg_open) begin
            if (cfg_node == NODE_W'(NUM_NODES)) begin
                out_cfg <= cfg_data[OP_W-1:0];
            end
            for (int i = 0; i < NUM_NODES; i++) begin
                if (cfg_node == NODE_W'(i)) node_cfg[i*CFG_W +: CFG_W] <= cfg_data;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and status outputs.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN: begin
                busy = 1'b1;
                if (final_hs) state_nx = DONE_ST;
            end
            DONE_ST: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Minterm counter, bit packer and output register with handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            m        <= '0;
            pack     <= '0;
            tt_data  <= '0;
            tt_valid <= 1'b0;
        end else begin
            if ((state == IDLE) && start) m <= '0;
            else if (advance)             m <= m + M_W'(1);
            if (advance) pack <= word_cat[TT_WORD-1:1];
            if (load) begin
                tt_data  <= word_cat;
                tt_valid <= 1'b1;
            end else if (tt_valid && tt_ready) begin
                tt_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mig_tt_engine.sv
// ============================================================================
// Module      : tb_mig_tt_engine
// Description : Directed self-checking bench for mig_tt_engine (default
//               parameters plus a 3-input / 8-bit-word instance).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mig_tt_engine;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cfg_we;
    logic [3:0]  cfg_node;
    logic [14:0] cfg_data;
    logic        start;
    logic        busy;
    logic [31:0] tt_data;
    logic        tt_valid;
    logic        tt_ready;
    logic        done;

    logic        s_cfg_we;
    logic [3:0]  s_cfg_node;
    logic [14:0] s_cfg_data;
    logic        s_start;
    logic        s_busy;
    logic [7:0]  s_tt_data;
    logic        s_tt_valid;
    logic        s_tt_ready;
    logic        s_done;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] got [4];
    int          hs_cyc [4];

    mig_tt_engine dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_node (cfg_node),
        .cfg_data (cfg_data),
        .start    (start),
        .busy     (busy),
        .tt_data  (tt_data),
        .tt_valid (tt_valid),
        .tt_ready (tt_ready),
        .done     (done)
    );

    mig_tt_engine #(
        .NUM_INPUTS (3),
        .NUM_NODES  (8),
        .TT_WORD    (8)
    ) dut_s (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (s_cfg_we),
        .cfg_node (s_cfg_node),
        .cfg_data (s_cfg_data),
        .start    (s_start),
        .busy     (s_busy),
        .tt_data  (s_tt_data),
        .tt_valid (s_tt_valid),
        .tt_ready (s_tt_ready),
        .done     (s_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] op(input logic inv, input int sel);
        return {inv, 4'(sel)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int node, input logic [14:0] data);
        cfg_we   = 1'b1;
        cfg_node = 4'(node);
        cfg_data = data;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic s_cfg(input int node, input logic [14:0] data);
        s_cfg_we   = 1'b1;
        s_cfg_node = 4'(node);
        s_cfg_data = data;
        step();
        s_cfg_we   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Accept nw words; optionally withhold ready for stall_cyc cycles on one word.
    task automatic collect(input int nw, input int stall_word, input int stall_cyc);
        int          n = 0;
        int          cyc = 0;
        logic [31:0] hold;
        logic        stable;
        logic        early = 1'b0;
        tt_ready = 1'b1;
        while (n < nw && cyc < 1000) begin
            if (tt_valid) begin
                if (n == stall_word) begin
                    hold     = tt_data;
                    stable   = 1'b1;
                    tt_ready = 1'b0;
                    for (int k = 0; k < stall_cyc; k++) begin
                        step();
                        cyc++;
                        if (!tt_valid || tt_data !== hold || done) stable = 1'b0;
                    end
                    chk("stall_hold", {31'b0, stable}, 32'd1);
                    tt_ready = 1'b1;
                end
                got[n]    = tt_data;
                hs_cyc[n] = cyc;
                n++;
            end
            step();
            cyc++;
            if (done && n < nw) early = 1'b1;
        end
        chk("word_count", n, nw);
        chk("no_early_done", {31'b0, early}, 32'd0);
    endtask

    task automatic check_end(input string tag);
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        step();
        chk({tag, "_done_once"}, {31'b0, done}, 32'd0);
    endtask

    task automatic check_words(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3);
        chk({tag, "_w0"}, got[0], e0);
        chk({tag, "_w1"}, got[1], e1);
        chk({tag, "_w2"}, got[2], e2);
        chk({tag, "_w3"}, got[3], e3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; cfg_we = 1'b0; cfg_node = '0; cfg_data = '0; start = 1'b0; tt_ready = 1'b0;
        s_cfg_we = 1'b0; s_cfg_node = '0; s_cfg_data = '0; s_start = 1'b0; s_tt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin got[i] = '0; hs_cyc[i] = 0; end
        step(); step(); step();

        // Reset state
        chk("rst_busy",   {31'b0, busy},     32'd0);
        chk("rst_valid",  {31'b0, tt_valid}, 32'd0);
        chk("rst_data",   tt_data,           32'd0);
        chk("rst_done",   {31'b0, done},     32'd0);
        chk("rst_s_valid", {31'b0, s_tt_valid}, 32'd0);
        rst = 1'b0;
        step();

        // Small instance: node0 = MAJ(x0,x1,x2), out = node0 -> 0xE8
        s_cfg(0, {op(0, 3), op(0, 2), op(0, 1)});
        s_cfg(8, {10'b0, op(0, 4)});
        s_tt_ready = 1'b1;
        s_start = 1'b1; step(); s_start = 1'b0;
        k = 0;
        while (!s_tt_valid && k < 100) begin step(); k++; end
        chk("s_valid_seen", {31'b0, s_tt_valid}, 32'd1);
        chk("s_word", {24'b0, s_tt_data}, 32'h0000_00E8);
        step();
        chk("s_done", {31'b0, s_done}, 32'd1);
        chk("s_busy", {31'b0, s_busy}, 32'd0);

        // node0 = MAJ(x0,x0,0) = x0 -> 0xAAAAAAAA, with steady throughput
        cfg(0, {op(0, 0), op(0, 1), op(0, 1)});
        cfg(8, {10'b0, op(0, 8)});
        pulse_start();
        collect(4, -1, 0);
        check_words("x0", 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA);
        chk("x0_spacing", hs_cyc[3] - hs_cyc[0], 32'd96);
        check_end("x0");

        // out = ~const0 -> all ones
        cfg(8, {10'b0, op(1, 0)});
        pulse_start();
        collect(4, -1, 0);
        check_words("one", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check_end("one");

        // Self/forward references read as 0: node1 = MAJ(node1,node5,x0) = 0
        do_reset();
        cfg(1, {op(0, 1), op(0, 13), op(0, 9)});
        cfg(8, {10'b0, op(1, 9)});
        pulse_start();
        collect(4, -1, 0);
        check_words("fwd", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check_end("fwd");

        // node0 = MAJ(x0,~x5,x6), node1 = MAJ(node0,x1,1), out = node1;
        // 50-cycle backpressure on word 1
        do_reset();
        cfg(0, {op(0, 7), op(1, 6), op(0, 1)});
        cfg(1, {op(1, 0), op(0, 2), op(0, 8)});
        cfg(8, {10'b0, op(0, 9)});
        pulse_start();
        collect(4, 1, 50);
        check_words("bp", 32'hEEEEEEEE, 32'hCCCCCCCC, 32'hFFFFFFFF, 32'hEEEEEEEE);
        check_end("bp");

        // Config write and start while busy must be ignored
        pulse_start();
        step(); step(); step();
        cfg_we = 1'b1; cfg_node = 4'd8; cfg_data = {10'b0, op(1, 0)}; start = 1'b1;
        step();
        cfg_we = 1'b0; start = 1'b0;
        collect(4, -1, 0);
        check_words("busy", 32'hEEEEEEEE, 32'hCCCCCCCC, 32'hFFFFFFFF, 32'hEEEEEEEE);
        check_end("busy");
        pulse_start();
        collect(4, -1, 0);
        check_words("rerun", 32'hEEEEEEEE, 32'hCCCCCCCC, 32'hFFFFFFFF, 32'hEEEEEEEE);
        check_end("rerun");

        // Reset mid-run with a word pending, then restart with cleared config
        pulse_start();
        collect(2, -1, 0);
        tt_ready = 1'b0;
        k = 0;
        while (!tt_valid && k < 100) begin step(); k++; end
        chk("mid_pending", {31'b0, tt_valid}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_valid", {31'b0, tt_valid}, 32'd0);
        chk("mid_busy",  {31'b0, busy},     32'd0);
        pulse_start();
        collect(4, -1, 0);
        check_words("clr", 32'h0, 32'h0, 32'h0, 32'h0);
        check_end("clr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mig_tt_engine.md
Name: mig_tt_engine

Overview:
- Programmable majority-inverter-graph (MIG) evaluator for the classification flow.
- Holds a configurable network of NUM_NODES three-input majority nodes over NUM_INPUTS primary inputs, with optional complement on every edge.
- On start, enumerates all 2^NUM_INPUTS minterms, one per cycle, and streams the resulting truth table as TT_WORD-bit words over a valid/ready interface.
- Replaces hand-written fixed majority netlists: one instance classifies any network that fits the parameters.

Parameters:
- NUM_INPUTS, 7, primary input count; minterm width.
- NUM_NODES, 8, majority node count.
- TT_WORD, 32, output word width; must be a power of two and no larger than 2^NUM_INPUTS.
- SEL_W, clog2(1+NUM_INPUTS+NUM_NODES), derived operand-select width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  config write strobe.
- cfg_node  in  clog2(NUM_NODES+1)  node index to write; index NUM_NODES selects the output register.
- cfg_data  in  3*(SEL_W+1)  three operands, each {inv, sel}; operand 0 in the LSBs. The output register uses only operand 0.
- start  in  1  begin enumeration.
- busy  out  1  high from start acceptance until done.
- tt_data  out  TT_WORD  truth-table word.
- tt_valid  out  1  tt_data valid.
- tt_ready  in  1  consumer accepts the word.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset:
  - All node and output config registers clear to 0 (every operand is constant 0, non-inverted).
  - State IDLE; busy=0, tt_valid=0, tt_data=0, done=0; minterm counter = 0.
- Operand decode, for sel value s:
  - s=0: constant 0.
  - s=1..NUM_INPUTS: x[s-1].
  - s=NUM_INPUTS+1..NUM_INPUTS+NUM_NODES: node[s-NUM_INPUTS-1].
  - Any s that references node j with j>=i inside node i (forward or self reference) reads as constant 0. Any s beyond the range also reads as constant 0.
  - The operand value is then XORed with its inv bit.
- Node value: MAJ(a,b,c) = ab|ac|bc. Nodes are evaluated combinationally in index order within one cycle.
- f = decoded output operand.
- Minterm m maps to x[i] = m[i]. Bit j of word w is f(m = w*TT_WORD + j).
- Words per run = 2^NUM_INPUTS / TT_WORD, emitted in ascending w.
- Config writes:
  - Take effect on the next edge, only when busy=0.
  - Ignored while busy.
  - cfg_node > NUM_NODES is ignored.
- FSM:
  - IDLE: start=1 -> RUN, busy=1, m=0. The cycle that accepts start sees no cfg write take effect.
  - RUN: each cycle evaluates f(m) into shift/pack register bit m mod TT_WORD, then m++.
    - When the last bit of a word is packed: if the output register is empty, load it and set tt_valid on the next cycle. Otherwise stall; m holds and no bit is computed.
  - Output register: tt_valid stays high and tt_data is held stable until tt_valid&tt_ready. Valid never drops without a handshake.
  - Simultaneous handshake and new word load in the same cycle is allowed, so there is no bubble with tt_ready held at 1.
  - After the final word handshakes: done=1 for one cycle, busy=0, return to IDLE.
  - start during busy is ignored.
- Latency: the first word has tt_valid=1 TT_WORD+1 cycles after the start edge. With tt_ready=1 throughout, one word every TT_WORD cycles.
- Full-width wrap: m is NUM_INPUTS+1 bits; enumeration ends at m=2^NUM_INPUTS. No wrap to 0 mid-run.
- rst mid-run: immediate return to reset state and config cleared. A pending tt_valid is dropped.

Decomposition:
- Package mig_pkg: SEL_W function, operand struct {inv, sel}, node config struct (3 operands), state enum {IDLE, RUN, DONE_ST}, constant SEL_CONST0=0.
- One sub-module, mig_eval: purely combinational network evaluation (config array + minterm -> f), reusable by the software-model cross-check bench.
- Top module holds the FSM, counter, pack register and handshake.

Test Plan:
- NUM_INPUTS=3, TT_WORD=8; node0 = MAJ(x0,x1,x2), out=node0; start, tt_ready=1 -> one word 0xE8, done pulses, busy drops.
- Defaults; node0 = MAJ(x0,x0,0), out=node0 -> 4 words, each 0xAAAAAAAA; out = ~const0 -> 4 words 0xFFFFFFFF.
- Defaults; node1 references node1 and node5 (self/forward), out=~node1 -> all words 0xFFFFFFFF (node1 = MAJ(0,0,x) = 0).
- Backpressure: tt_ready low for 50 cycles on word 1 -> tt_data held stable, m stalls, 4 correct words total, done only after the last handshake.
- cfg_we and start asserted during busy -> no effect; the subsequent run reproduces the original truth table.
- rst asserted after 2 words -> tt_valid=0, busy=0 next cycle; restart without reconfig -> all words 0x00000000.
